// File: rtl/pulse_det_pkg.sv
// Shared definitions for the burst detector: FSM state encoding and the default
// thresholds also used by the pulsed-sine generator's test configuration.
package pulse_det_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ON     = 2'd1,
    OFF    = 2'd2
  } state_t;

  localparam int DEF_DW           = 16;
  localparam int DEF_CNT_W        = 24;
  localparam int DEF_THRESH_ON    = 1000;
  localparam int DEF_THRESH_OFF   = 800;
  localparam int DEF_HOLD_SAMPLES = 4;

endpackage

// File: rtl/pulse_detector_sat_abs.sv
// Combinational saturating magnitude: |data_i| on DW-1 bits, with the most
// negative input clamped to the largest representable magnitude.
module sat_abs #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] data_i,
  output logic [DW-2:0] mag_o
);

  localparam logic [DW-2:0] MAG_MAX = {(DW-1){1'b1}};
  localparam logic [DW-2:0] MAG_ONE = {{(DW-2){1'b0}}, 1'b1};

  // Negation only needs the low DW-1 bits because |x| < 2^(DW-1) once -2^(DW-1) is excluded.
  always_comb begin
    if (data_i[DW-1] == 1'b0) begin
      mag_o = data_i[DW-2:0];
    end else if (data_i[DW-2:0] == {(DW-1){1'b0}}) begin
      mag_o = MAG_MAX;
    end else begin
      mag_o = ~data_i[DW-2:0] + MAG_ONE;
    end
  end

endmodule

// File: rtl/pulse_detector.sv
// Burst detector: thresholded magnitude with hysteresis and hold-off, reporting
// pulse width / repetition interval. Optional peak report via PULSE_DET_PEAK_EN.
module pulse_detector
  import pulse_det_pkg::*;
#(
  parameter int DW           = DEF_DW,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int THRESH_ON    = DEF_THRESH_ON,
  parameter int THRESH_OFF   = DEF_THRESH_OFF,
  parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] data_i,
  input  logic                 valid_i,
  output logic                 active_o,
  output logic [CNT_W-1:0]     pw_o,
  output logic [CNT_W-1:0]     pri_o,
  output logic                 sat_o,
  output logic                 meas_valid_o
`ifdef PULSE_DET_PEAK_EN
  ,
  output logic [DW-2:0]        peak_o
`endif
);

  localparam int                HOLD_W   = $clog2(HOLD_SAMPLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_C   = HOLD_W'(HOLD_SAMPLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DW-2:0]     TH_ON_C  = (DW-1)'(THRESH_ON);
  localparam logic [DW-2:0]     TH_OFF_C = (DW-1)'(THRESH_OFF);

  logic [DW-2:0]     mag_s;
  logic              above_on_s;
  logic              above_off_s;
  logic              edge_at_max_s;
  logic [CNT_W-1:0]  edge_inc_s;
  logic [HOLD_W-1:0] below_inc_s;

  state_t            state_r;
  logic [CNT_W-1:0]  edge_cnt_r;
  logic [CNT_W-1:0]  last_above_r;
  logic [CNT_W-1:0]  pw_hold_r;
  logic              pw_sat_r;
  logic [HOLD_W-1:0] below_cnt_r;
`ifdef PULSE_DET_PEAK_EN
  logic [DW-2:0]     peak_r;
`endif

  sat_abs #(.DW(DW)) u_sat_abs (
    .data_i (data_i),
    .mag_o  (mag_s)
  );

  assign above_on_s    = (mag_s >= TH_ON_C);
  assign above_off_s   = (mag_s >= TH_OFF_C);
  assign edge_at_max_s = (edge_cnt_r == CNT_MAX);
  assign edge_inc_s    = edge_at_max_s ? CNT_MAX : (edge_cnt_r + CNT_ONE);
  assign below_inc_s   = below_cnt_r + HOLD_ONE;

  // Burst FSM, sample counters and registered measurement outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= SEARCH;
      edge_cnt_r   <= CNT_ZERO;
      last_above_r <= CNT_ZERO;
      pw_hold_r    <= CNT_ZERO;
      pw_sat_r     <= 1'b0;
      below_cnt_r  <= {HOLD_W{1'b0}};
      active_o     <= 1'b0;
      pw_o         <= CNT_ZERO;
      pri_o        <= CNT_ZERO;
      sat_o        <= 1'b0;
      meas_valid_o <= 1'b0;
`ifdef PULSE_DET_PEAK_EN
      peak_r       <= {(DW-1){1'b0}};
      peak_o       <= {(DW-1){1'b0}};
`endif
    end else begin
      meas_valid_o <= 1'b0;
      if (valid_i) begin
        case (state_r)
          SEARCH: begin
            if (above_on_s) begin
              state_r      <= ON;
              active_o     <= 1'b1;
              edge_cnt_r   <= CNT_ZERO;
              below_cnt_r  <= {HOLD_W{1'b0}};
              last_above_r <= CNT_ZERO;
`ifdef PULSE_DET_PEAK_EN
              peak_r       <= mag_s;
`endif
            end
          end
          ON: begin
            edge_cnt_r <= edge_inc_s;
`ifdef PULSE_DET_PEAK_EN
            if (mag_s > peak_r) begin
              peak_r <= mag_s;
            end
`endif
            if (above_off_s) begin
              below_cnt_r  <= {HOLD_W{1'b0}};
              last_above_r <= edge_inc_s;
            end else if (below_inc_s == HOLD_C) begin
              // Only a last-above index already at the counter ceiling makes pw overflow.
              state_r     <= OFF;
              active_o    <= 1'b0;
              below_cnt_r <= {HOLD_W{1'b0}};
              pw_hold_r   <= (last_above_r == CNT_MAX) ? CNT_MAX : (last_above_r + CNT_ONE);
              pw_sat_r    <= (last_above_r == CNT_MAX);
            end else begin
              below_cnt_r <= below_inc_s;
            end
          end
          OFF: begin
            if (above_on_s) begin
              state_r      <= ON;
              active_o     <= 1'b1;
              meas_valid_o <= 1'b1;
              pw_o         <= pw_hold_r;
              pri_o        <= edge_inc_s;
              sat_o        <= pw_sat_r | edge_at_max_s;
              edge_cnt_r   <= CNT_ZERO;
              below_cnt_r  <= {HOLD_W{1'b0}};
              last_above_r <= CNT_ZERO;
`ifdef PULSE_DET_PEAK_EN
              peak_o       <= peak_r;
              peak_r       <= mag_s;
`endif
            end else if (edge_inc_s == CNT_MAX) begin
              // Gap too long to measure: abandon the pending report.
              state_r    <= SEARCH;
              edge_cnt_r <= CNT_ZERO;
            end else begin
              edge_cnt_r <= edge_inc_s;
            end
          end
          default: begin
            state_r  <= SEARCH;
            active_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_detector.sv
// Scoreboard bench for pulse_detector: directed bursts on a 24-bit and a 6-bit
// counter instance, expected strobes queued at stimulus time and checked by monitors.
module tb_pulse_detector;

  typedef struct packed {
    logic [23:0] pw;
    logic [23:0] pri;
    logic        sat;
    logic [14:0] peak;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] data_a, data_b;
  logic valid_a, valid_b;
  logic a_active, a_sat, a_mv, b_active, b_sat, b_mv;
  logic [23:0] a_pw, a_pri;
  logic [5:0]  b_pw, b_pri;
  logic [14:0] a_peak, b_peak;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;

  logic signed [15:0] sine_t [16] = '{
    16'sd0, 16'sd765, 16'sd1414, 16'sd1848, 16'sd2000, 16'sd1848, 16'sd1414, 16'sd765,
    16'sd0, -16'sd765, -16'sd1414, -16'sd1848, -16'sd2000, -16'sd1848, -16'sd1414, -16'sd765};

  always #5 clk = ~clk;

  pulse_detector #(.DW(16), .CNT_W(24)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_a),
    .valid_i      (valid_a),
    .active_o     (a_active),
    .pw_o         (a_pw),
    .pri_o        (a_pri),
    .sat_o        (a_sat),
    .meas_valid_o (a_mv)
`ifdef PULSE_DET_PEAK_EN
    ,
    .peak_o       (a_peak)
`endif
  );

  pulse_detector #(.DW(16), .CNT_W(6)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_b),
    .valid_i      (valid_b),
    .active_o     (b_active),
    .pw_o         (b_pw),
    .pri_o        (b_pri),
    .sat_o        (b_sat),
    .meas_valid_o (b_mv)
`ifdef PULSE_DET_PEAK_EN
    ,
    .peak_o       (b_peak)
`endif
  );

`ifndef PULSE_DET_PEAK_EN
  assign a_peak = 15'd0;
  assign b_peak = 15'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor for instance A: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (a_mv === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        ea = q_a.pop_front();
        check("a_pw", {8'd0, a_pw}, {8'd0, ea.pw});
        check("a_pri", {8'd0, a_pri}, {8'd0, ea.pri});
        check("a_sat", {31'd0, a_sat}, {31'd0, ea.sat});
`ifdef PULSE_DET_PEAK_EN
        check("a_peak", {17'd0, a_peak}, {17'd0, ea.peak});
`endif
      end
    end
  end

  // Monitor for instance B (6-bit counters).
  always @(negedge clk) begin
    if (b_mv === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        eb = q_b.pop_front();
        check("b_pw", {26'd0, b_pw}, {8'd0, eb.pw});
        check("b_pri", {26'd0, b_pri}, {8'd0, eb.pri});
        check("b_sat", {31'd0, b_sat}, {31'd0, eb.sat});
`ifdef PULSE_DET_PEAK_EN
        check("b_peak", {17'd0, b_peak}, {17'd0, eb.peak});
`endif
      end
    end
  end

  task automatic step(input bit sel_b, input logic signed [15:0] v, input logic vld);
    if (sel_b) begin
      data_b = v; valid_b = vld; data_a = 16'sd0; valid_a = 1'b0;
    end else begin
      data_a = v; valid_a = vld; data_b = 16'sd0; valid_b = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic square(input bit sel_b, input int n);
    for (int i = 0; i < n; i++) step(sel_b, (i % 2 == 1) ? -16'sd2000 : 16'sd2000, 1'b1);
  endtask

  task automatic zeros(input bit sel_b, input int n);
    for (int i = 0; i < n; i++) step(sel_b, 16'sd0, 1'b1);
  endtask

  task automatic push(input bit sel_b, input int pw, input int pri, input bit sat, input int peak);
    exp_t e;
    e.pw = pw[23:0]; e.pri = pri[23:0]; e.sat = sat; e.peak = peak[14:0];
    if (sel_b) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  initial begin
    rst = 1'b1; data_a = 16'sd0; data_b = 16'sd0; valid_a = 1'b0; valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", {31'd0, a_active}, 32'd0);
    check("rst_pw", {8'd0, a_pw}, 32'd0);
    check("rst_pri", {8'd0, a_pri}, 32'd0);
    check("rst_sat", {31'd0, a_sat}, 32'd0);
    check("rst_mv", {31'd0, a_mv}, 32'd0);
    check("rst_peak", {17'd0, a_peak}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three square bursts: first start silent, later starts report 40/100.
    square(1'b0, 1);
    check("first_start_active", {31'd0, a_active}, 32'd1);
    square(1'b0, 39); zeros(1'b0, 60);
    push(1'b0, 40, 100, 1'b0, 2000); square(1'b0, 40); zeros(1'b0, 60);
    push(1'b0, 40, 100, 1'b0, 2000); square(1'b0, 40); zeros(1'b0, 60);

    // Sine burst with zero crossings stays one burst.
    push(1'b0, 40, 100, 1'b0, 2000);
    for (int j = 0; j < 37; j++) begin
      step(1'b0, sine_t[(j + 2) % 16], 1'b1);
      check("sine_active", {31'd0, a_active}, 32'd1);
    end
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 16'sd0, 1'b1);
      check("hold_active", {31'd0, a_active}, 32'd1);
    end
    step(1'b0, 16'sd0, 1'b1);
    check("burst_end", {31'd0, a_active}, 32'd0);
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 16'sd900, 1'b1);
      check("hyst_no_restart", {31'd0, a_active}, 32'd0);
    end

    // Exactly THRESH_ON restarts; pri includes the 900-level samples.
    push(1'b0, 37, 61, 1'b0, 2000);
    step(1'b0, 16'sd1000, 1'b1);
    check("restart_at_1000", {31'd0, a_active}, 32'd1);
    for (int j = 0; j < 9; j++) step(1'b0, -16'sd32768, 1'b1);
    zeros(1'b0, 30);

    // A burst triggered by the most negative sample.
    push(1'b0, 10, 40, 1'b0, 32767);
    step(1'b0, -16'sd32768, 1'b1);
    check("min_neg_trigger", {31'd0, a_active}, 32'd1);
    for (int j = 0; j < 4; j++) step(1'b0, -16'sd32768, 1'b1);
    zeros(1'b0, 20);
    push(1'b0, 5, 25, 1'b0, 32767);
    square(1'b0, 2);

    // Asynchronous reset mid-burst.
    valid_a = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_active", {31'd0, a_active}, 32'd0);
    check("async_rst_pw", {8'd0, a_pw}, 32'd0);
    check("async_rst_pri", {8'd0, a_pri}, 32'd0);
    check("async_rst_peak", {17'd0, a_peak}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_mv", {31'd0, a_mv}, 32'd0);
    check("rst_hold_sat", {31'd0, a_sat}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    square(1'b0, 10); zeros(1'b0, 20);
    push(1'b0, 10, 30, 1'b0, 2000); square(1'b0, 10);
    zeros(1'b0, 10);
    for (int j = 0; j < 10; j++) step(1'b0, 16'sd2000, 1'b0);
    zeros(1'b0, 10);
    push(1'b0, 10, 30, 1'b0, 2000); square(1'b0, 10); zeros(1'b0, 4);

    // 6-bit counters: saturation in ON, then drop to SEARCH on a long gap.
    square(1'b1, 70); zeros(1'b1, 4);
    push(1'b1, 63, 63, 1'b1, 2000); square(1'b1, 10); zeros(1'b1, 100);
    square(1'b1, 10); zeros(1'b1, 20);
    push(1'b1, 10, 30, 1'b0, 2000); square(1'b1, 10); zeros(1'b1, 20);

    repeat (3) @(posedge clk);
    #1;
    check("a_pending", q_a.size(), 32'd0);
    check("b_pending", q_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
